// File: rtl/led_pwm_pkg.sv
// Shared types and default parameters for the LED PWM driver.
// The breathing FSM walks the duty between B_MIN and B_MAX in STEP increments.
package led_pwm_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int STEP_DEF  = 8;
  localparam int B_MIN_DEF = 8;
  localparam int B_MAX_DEF = 248;

  typedef enum logic [1:0] {
    MANUAL,
    UP,
    DOWN
  } state_t;

endpackage

// File: rtl/led_pwm_driver_if.sv
// Manual-duty valid/ready handshake between a duty source and the PWM driver.
interface led_pwm_driver_if
  import led_pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             duty_valid;
  logic [WIDTH-1:0] duty_data;
  logic             duty_ready;

  modport master (
    output duty_valid,
    output duty_data,
    input  duty_ready
  );

  modport slave (
    input  duty_valid,
    input  duty_data,
    output duty_ready
  );

endinterface

// File: rtl/led_pwm_driver_tick_detect.sv
// Rising-edge detector for the divided pwm_clk, sampled in the sys_clk domain.
// Produces one tick per pwm_clk rising edge.
module pwm_tick_detect (
  input  logic sys_clk,
  input  logic rst,
  input  logic pwm_clk,
  output logic tick
);

  logic r_pwm_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_pwm_q <= 1'b0;
    end else begin
      r_pwm_q <= pwm_clk;
    end
  end

  assign tick = pwm_clk & ~r_pwm_q;

endmodule

// File: rtl/led_pwm_driver.sv
// LED PWM driver: free-running period counter, shadowed manual duty, and a
// breathing FSM that ramps the duty between B_MIN and B_MAX once per period.
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = STEP_DEF,
  parameter int B_MIN = B_MIN_DEF,
  parameter int B_MAX = B_MAX_DEF
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   pwm_clk,
  led_pwm_driver_if.slave        duty_if,
  input  logic                   breathe_en,
  output logic                   led_out,
  output logic                   period_start
);

  localparam logic [WIDTH-1:0] P_MIN_W    = WIDTH'(B_MIN);
  localparam logic [WIDTH-1:0] P_MAX_W    = WIDTH'(B_MAX);
  localparam logic [WIDTH-1:0] P_STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH:0]   P_MAX_X    = (WIDTH+1)'(B_MAX);
  localparam logic [WIDTH:0]   P_STEP_X   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   P_DOWN_THR = (WIDTH+1)'(B_MIN) + P_STEP_X;

  logic             w_tick;
  logic             w_boundary;
  logic             w_ready;
  logic             w_transfer;
  logic [WIDTH:0]   w_sum_up;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_active_duty;
  logic [WIDTH-1:0] r_shadow;
  logic             r_pending;
  state_t           r_state;
  logic             r_led_out;
  logic             r_period_start;

  pwm_tick_detect u_tick (
    .sys_clk (sys_clk),
    .rst     (rst),
    .pwm_clk (pwm_clk),
    .tick    (w_tick)
  );

  assign w_boundary = w_tick & (r_cnt == '1);
  assign w_ready    = ~r_pending & (r_state == MANUAL) & ~rst;
  assign w_transfer = duty_if.duty_valid & w_ready;
  // Widened so a ramp near the top of the range cannot wrap past B_MAX.
  assign w_sum_up   = {1'b0, r_active_duty} + P_STEP_X;

  assign duty_if.duty_ready = w_ready;
  assign led_out            = r_led_out;
  assign period_start       = r_period_start;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_active_duty  <= '0;
      r_shadow       <= '0;
      r_pending      <= 1'b0;
      r_state        <= MANUAL;
      r_led_out      <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_led_out      <= (r_cnt < r_active_duty);
      r_period_start <= w_boundary;

      if (w_tick) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // A transfer landing on a boundary only fills the shadow; it is applied next period.
      if (w_transfer) begin
        r_shadow  <= duty_if.duty_data;
        r_pending <= 1'b1;
      end

      if (w_boundary) begin
        case (r_state)
          MANUAL: begin
            if (breathe_en) begin
              r_state       <= UP;
              r_active_duty <= P_MIN_W;
              r_pending     <= 1'b0;
            end else if (r_pending) begin
              r_active_duty <= r_shadow;
              r_pending     <= 1'b0;
            end
          end
          UP: begin
            if (!breathe_en) begin
              r_state <= MANUAL;
            end else if (w_sum_up >= P_MAX_X) begin
              r_active_duty <= P_MAX_W;
              r_state       <= DOWN;
            end else begin
              r_active_duty <= w_sum_up[WIDTH-1:0];
            end
          end
          DOWN: begin
            if (!breathe_en) begin
              r_state <= MANUAL;
            end else if ({1'b0, r_active_duty} <= P_DOWN_THR) begin
              r_active_duty <= P_MIN_W;
              r_state       <= UP;
            end else begin
              r_active_duty <= r_active_duty - P_STEP_W;
            end
          end
          default: r_state <= MANUAL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver: a per-period high-count scoreboard
// plus directed sequences for boundary handshakes, breathing and reset abort.
module tb_led_pwm_driver;

  typedef struct {
    int duty;
    int exp_ticks;
  } vec_t;

  typedef struct {
    int idx;
    int ticks;
  } sb_t;

  logic sys_clk;
  logic rst;
  logic pwm_clk;
  logic breathe_en;
  logic led_out;
  logic period_start;

  led_pwm_driver_if #(.WIDTH(8)) duty_if ();

  led_pwm_driver dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .pwm_clk      (pwm_clk),
    .duty_if      (duty_if),
    .breathe_en   (breathe_en),
    .led_out      (led_out),
    .period_start (period_start)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  sb_t  sb[$];
  sb_t  mon_e;
  int   win_done = 0;
  int   high_cnt = 0;
  int   cyc_in_win = 0;
  int   last_len = 0;
  bit   prev_ready = 0;
  bit   ps_prev_ready = 0;
  bit   ready_watch = 0;
  int   ready_hits = 0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // pwm_clk toggles every sys_clk cycle: one tick every two cycles, 512 cycles per period.
  initial begin
    pwm_clk = 1'b0;
    #10;
    forever #10 pwm_clk = ~pwm_clk;
  end

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic push_exp(input int idx, input int ticks);
    sb_t e;
    e.idx   = idx;
    e.ticks = ticks;
    sb.push_back(e);
  endtask

  // Window k covers the cycles after one period_start up to and including the next.
  always @(negedge sys_clk) begin
    cyc_in_win++;
    if (led_out) high_cnt++;
    if (ready_watch && duty_if.duty_ready) ready_hits++;
    if (period_start) begin
      while (sb.size() > 0 && sb[0].idx < win_done) begin
        mon_e = sb.pop_front();
        check($sformatf("sb_stale_win%0d", mon_e.idx), mon_e.idx, win_done);
      end
      if (sb.size() > 0 && sb[0].idx == win_done) begin
        mon_e = sb.pop_front();
        check($sformatf("win%0d_high_cycles", mon_e.idx), high_cnt, 2 * mon_e.ticks);
      end
      last_len      = cyc_in_win;
      ps_prev_ready = prev_ready;
      high_cnt      = 0;
      cyc_in_win    = 0;
      win_done++;
    end
    prev_ready = duty_if.duty_ready;
  end

  task automatic wait_ps(input string name);
    int start = win_done;
    bit got = 0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge sys_clk);
      #1;
      if (win_done != start) begin
        got = 1;
        break;
      end
    end
    if (!got) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_win(input int target);
    for (int k = 0; k < 200; k++) begin
      if (win_done >= target) break;
      wait_ps("wait_win");
    end
    if (win_done < target) check("wait_win_reached", win_done, target);
  endtask

  task automatic send_duty(input int d);
    bit ok = 0;
    duty_if.duty_valid = 1'b1;
    duty_if.duty_data  = 8'(d);
    for (int k = 0; k < 2000; k++) begin
      if (duty_if.duty_ready) begin
        ok = 1;
        break;
      end
      @(negedge sys_clk);
      #1;
    end
    @(posedge sys_clk);
    #1;
    duty_if.duty_valid = 1'b0;
    if (!ok) check("send_ready_timeout", 0, 1);
  endtask

  vec_t vecs[4];

  initial begin
    int w;
    int wb;
    int wl;
    int n;
    int v;
    int high_after;

    vecs = '{'{64, 64}, '{0, 0}, '{255, 255}, '{128, 128}};

    rst                = 1'b1;
    breathe_en         = 1'b0;
    duty_if.duty_valid = 1'b0;
    duty_if.duty_data  = '0;

    repeat (3) @(negedge sys_clk);
    check("rst_led_out", led_out, 0);
    check("rst_period_start", period_start, 0);
    check("rst_duty_ready", duty_if.duty_ready, 0);
    #1;
    rst = 1'b0;
    #1;
    check("ready_after_reset", duty_if.duty_ready, 1);

    // Manual duty table: each value must own the whole period after its boundary.
    wait_ps("align");
    for (int i = 0; i < 4; i++) begin
      w = win_done;
      send_duty(vecs[i].duty);
      push_exp(w + 1, vecs[i].exp_ticks);
      wait_ps("apply");
      check($sformatf("ready_back_%0d", vecs[i].duty), duty_if.duty_ready, 1);
      check($sformatf("ready_low_at_bnd_%0d", vecs[i].duty), ps_prev_ready, 0);
    end
    wait_ps("flush_tbl");
    check("period_len", last_len, 512);

    // Offer 100 on the exact boundary cycle while 50 is active.
    w = win_done;
    send_duty(50);
    push_exp(w + 1, 50);
    wait_ps("apply50");
    repeat (511) @(negedge sys_clk);
    #1;
    check("ready_on_boundary", duty_if.duty_ready, 1);
    duty_if.duty_valid = 1'b1;
    duty_if.duty_data  = 8'd100;
    w = win_done;
    @(posedge sys_clk);
    #1;
    duty_if.duty_valid = 1'b0;
    @(negedge sys_clk);
    #1;
    check("boundary_align", win_done, w + 1);
    check("ready_pending_after_bnd", duty_if.duty_ready, 0);
    push_exp(w + 1, 50);
    push_exp(w + 2, 100);
    wait_win(w + 3);

    // Breathing ramp, then drop breathe_en at 120 on the way up.
    breathe_en = 1'b1;
    wb = win_done;
    n  = 0;
    for (v = 8; v <= 248; v += 8) begin push_exp(wb + 1 + n, v); n++; end
    for (v = 240; v >= 8; v -= 8) begin push_exp(wb + 1 + n, v); n++; end
    for (v = 16; v <= 120; v += 8) begin push_exp(wb + 1 + n, v); n++; end
    wl = wb + n;
    wait_ps("breathe_start");
    ready_watch = 1;
    wait_win(wl);
    ready_watch = 0;
    check("ready_low_breathe", ready_hits, 0);
    breathe_en = 1'b0;
    push_exp(wl + 1, 120);
    wait_ps("breathe_stop");
    check("ready_after_breathe", duty_if.duty_ready, 1);
    wait_win(wl + 2);

    // Reset for one cycle at cnt=130 during a DOWN period.
    breathe_en = 1'b1;
    wb = win_done;
    for (int i = 0; i < 31; i++) push_exp(wb + 1 + i, 8 + 8 * i);
    wait_win(wb + 32);
    repeat (260) @(negedge sys_clk);
    #1;
    rst        = 1'b1;
    breathe_en = 1'b0;
    @(negedge sys_clk);
    check("midrst_led_out", led_out, 0);
    check("midrst_period_start", period_start, 0);
    check("midrst_duty_ready", duty_if.duty_ready, 0);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_manual_ready", duty_if.duty_ready, 1);
    high_after = 0;
    n = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge sys_clk);
      if (led_out) high_after++;
      if (period_start) begin
        n = k;
        break;
      end
    end
    check("rst_to_period_start", n, 511);
    check("led_after_rst", high_after, 0);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the PWM counter and duty width.
REQ-002 The block SHALL have parameter STEP, default 8, which sets the breathing duty increment/decrement per PWM period.
REQ-003 The block SHALL have parameter B_MIN, default 8, which sets the breathing lower duty bound.
REQ-004 The block SHALL have parameter B_MAX, default 248, which sets the breathing upper duty bound; B_MIN < B_MAX <= 2^WIDTH-1.
REQ-005 The block SHALL have one clock and one reset, as follows: sys_clk  in  1  sole clock; rst  in  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port pwm_clk  in  1  divided tick source from the clock block, sampled in sys_clk.
REQ-007 The block SHALL have port duty_valid  in  1  new manual duty offered.
REQ-008 The block SHALL have port duty_data  in  WIDTH  manual duty value.
REQ-009 The block SHALL have port duty_ready  out  1  shadow register free to accept duty.
REQ-010 The block SHALL have port breathe_en  in  1  request for breathing mode.
REQ-011 The block SHALL have port led_out  out  1  registered PWM output.
REQ-012 The block SHALL have port period_start  out  1  one-cycle pulse at each PWM period boundary.

Function
REQ-013 Tick SHALL be pwm_clk & ~pwm_q, where pwm_q is pwm_clk registered on sys_clk, giving one tick per pwm_clk rising edge, one sys_clk cycle late.
REQ-014 On each tick, cnt (WIDTH bits) SHALL increment modulo 2^WIDTH; cnt SHALL hold on all other cycles.
REQ-015 A boundary SHALL be the cycle where tick=1 and cnt=2^WIDTH-1; period_start SHALL be 1 on the next cycle for exactly one cycle.
REQ-016 led_out SHALL be registered (cnt < active_duty), updated every cycle, so duty 0 gives constant low and duty 255 gives high for 255 of 256 ticks.
REQ-017 A handshake transfer SHALL occur when duty_valid & duty_ready; it loads shadow <= duty_data and sets pending=1.
REQ-018 duty_ready SHALL equal ~pending & (state==MANUAL) & ~rst.
REQ-019 In MANUAL, at a boundary with pending=1, active_duty SHALL load from shadow, pending SHALL clear, and duty_ready SHALL rise on the following cycle.
REQ-020 If a transfer coincides with a boundary while pending=0, the value SHALL be held in shadow and applied at the next boundary, not the current one.
REQ-021 active_duty SHALL change only at boundaries; no mid-period glitch is permitted.
REQ-022 The FSM SHALL have states MANUAL, UP and DOWN, evaluated only at boundaries.
REQ-023 MANUAL with breathe_en=1 SHALL go to UP, with active_duty <= B_MIN and pending cleared (shadow discarded).
REQ-024 UP: if active_duty + STEP >= B_MAX, active_duty SHALL load B_MAX and state SHALL go to DOWN; otherwise active_duty SHALL add STEP. The sum SHALL be computed at WIDTH+1 bits, with no wrap.
REQ-025 DOWN: if active_duty <= B_MIN + STEP, active_duty SHALL load B_MIN and state SHALL go to UP; otherwise active_duty SHALL subtract STEP.
REQ-026 UP or DOWN with breathe_en=0 at a boundary SHALL go to MANUAL, holding the current active_duty.
REQ-027 In UP and DOWN, duty_valid SHALL be ignored, since duty_ready=0.
REQ-028 breathe_en changes between boundaries SHALL have no effect until the next boundary.

Reset
REQ-029 While rst=1 at a sys_clk edge, the block SHALL set pwm_q=0, cnt=0, active_duty=0, shadow=0, pending=0, state=MANUAL, led_out=0, period_start=0; duty_ready SHALL be 0 while rst=1.
REQ-030 Reset asserted mid-period or mid-breathe SHALL abort immediately; the first boundary after release SHALL occur 256 ticks later.

Structure
REQ-031 Package led_pwm_pkg SHALL hold the FSM state enum (MANUAL, UP, DOWN) and the default WIDTH, STEP, B_MIN and B_MAX constants.
REQ-032 Sub-module pwm_tick_detect SHALL contain the pwm_q register and edge logic, with ports sys_clk, rst, pwm_clk and tick.

Verification
REQ-033 Bench SHALL drive duty 64 via handshake, then run 2 periods -> led_out high for exactly 64 of 256 ticks in the second period; duty_ready returns high 1 cycle after the boundary.
REQ-034 Bench SHALL drive duty 0, then duty 255 -> led_out constant 0; then 255 of 256 ticks high; no high tick in the period of change.
REQ-035 Bench SHALL offer a transfer of 100 on the exact boundary cycle while 50 is active -> 50 persists one more period, then 100 is applied.
REQ-036 Bench SHALL set breathe_en=1 with defaults -> duty sequence 8,16,...,240,248,240,...,16,8,16 at successive boundaries; duty_ready=0 throughout.
REQ-037 Bench SHALL drop breathe_en at duty 120 while in UP -> MANUAL at next boundary, duty holds 120, duty_ready=1.
REQ-038 Bench SHALL assert rst for 1 cycle at cnt=130 while in DOWN -> all outputs 0, state MANUAL, cnt 0; next period_start after 256 ticks.
